// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment readback path: patterns, digit codes, scan states.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    // Segment patterns ordered a..g (MSB = a), decimal point excluded.
    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    localparam logic [3:0] DIG_DASH = 4'hA;
    localparam logic [3:0] DIG_BAD  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } scan_state_e;

    // Display position of a one-hot digit select: bit7 is position 0.
    function automatic logic [2:0] onehot_pos(input logic [7:0] which);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (which[i]) pos = 3'(7 - i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/seg_scan_monitor_if.sv
// Scan bus plus frame readback outputs of the segment scan monitor.
// Latency: n/a (signal bundle only).
// Backpressure: none; the scan bus is free-running and frame outputs are level/pulse.
// master: drives seg_which/seg_data, observes frame outputs. slave: the monitor.
interface seg_scan_monitor_if;
    logic [7:0]  seg_which;
    logic [7:0]  seg_data;
    logic [31:0] digits_o;
    logic [7:0]  present_o;
    logic        frame_valid_o;
    logic        scan_active_o;
    logic        err_o;

    modport master (
        output seg_which, seg_data,
        input  digits_o, present_o, frame_valid_o, scan_active_o, err_o
    );

    modport slave (
        input  seg_which, seg_data,
        output digits_o, present_o, frame_valid_o, scan_active_o, err_o
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Maps a 7-bit segment pattern (a..g) to a digit code; unknown patterns give DIG_BAD.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern in (7), code out (4), illegal out (1, high for any unlisted pattern).
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = DIG_BAD;
        illegal = 1'b0;
        case (pattern)
            SEG_0:    code = 4'd0;
            SEG_1:    code = 4'd1;
            SEG_2:    code = 4'd2;
            SEG_3:    code = 4'd3;
            SEG_4:    code = 4'd4;
            SEG_5:    code = 4'd5;
            SEG_6:    code = 4'd6;
            SEG_7:    code = 4'd7;
            SEG_8:    code = 4'd8;
            SEG_9:    code = 4'd9;
            SEG_DASH: code = DIG_DASH;
            default: begin
                code    = DIG_BAD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_monitor.sv
// Samples a multiplexed 7-seg scan, filters settling, decodes and rebuilds 8-digit frames.
// Latency: capture STABLE_CYC cycles after the pair settles; frame publishes 1 cycle after the wrap capture.
// Backpressure: none; the scan is observed passively and frames are single-cycle pulses.
// Ports: clk, rst (async active-low), bus (slave): seg_which/seg_data in; digits_o, present_o,
//        frame_valid_o, scan_active_o, err_o out.
module seg_scan_monitor
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 500000,
    parameter int TMO_W       = 20
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_monitor_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] STAB_FIRE = CNT_W'(STABLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    // ---------------- stability filter ----------------
    logic [15:0]      pair_in;
    logic [15:0]      pair_q;
    logic [CNT_W-1:0] stab_cnt;

    assign pair_in = {bus.seg_which, bus.seg_data};

    // Counter saturates one past the fire value so a held pair captures only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_q   <= '0;
            stab_cnt <= '0;
        end else begin
            pair_q <= pair_in;
            if (pair_in != pair_q)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // ---------------- capture qualification and decode ----------------
    logic       capture;
    logic [7:0] cap_which;
    logic       cap_onehot;
    logic       cap_multi;
    logic       qual;
    logic [2:0] cap_p;
    logic [3:0] dec_code;
    logic       dec_bad;
    logic [4:0] slot_sh;
    logic [31:0] slot_dig;
    logic [7:0]  slot_msk;

    assign capture    = (stab_cnt == STAB_FIRE);
    assign cap_which  = pair_q[15:8];
    assign cap_onehot = $onehot(cap_which);
    assign cap_multi  = capture && (cap_which != 8'h00) && !cap_onehot;
    assign qual       = capture && cap_onehot;
    assign cap_p      = onehot_pos(cap_which);

    seg_pattern_decode u_decode (
        .pattern (pair_q[7:1]),
        .code    (dec_code),
        .illegal (dec_bad)
    );

    // Position 0 sits in the top nibble, so shift by 4*(7-p); 7-p == ~p for 3 bits.
    assign slot_sh  = {~cap_p, 2'b00};
    assign slot_dig = {28'd0, dec_code} << slot_sh;
    assign slot_msk = 8'h80 >> cap_p;

    // ---------------- frame assembly FSM ----------------
    scan_state_e      state_q, state_d;
    logic [2:0]       last_p_q, last_p_d;
    logic [31:0]      acc_dig_q, acc_dig_d;
    logic [7:0]       acc_msk_q, acc_msk_d;
    logic [31:0]      digits_q, digits_d;
    logic [7:0]       present_q, present_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wrap;

    // A repeated position also closes the frame, hence <=.
    assign wrap = (cap_p <= last_p_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_p_q  <= '0;
            acc_dig_q <= '0;
            acc_msk_q <= '0;
            digits_q  <= '0;
            present_q <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_p_q  <= last_p_d;
            acc_dig_q <= acc_dig_d;
            acc_msk_q <= acc_msk_d;
            digits_q  <= digits_d;
            present_q <= present_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_p_d  = last_p_q;
        acc_dig_d = acc_dig_q;
        acc_msk_d = acc_msk_q;
        digits_d  = digits_q;
        present_d = present_q;
        fv_d      = 1'b0;
        err_d     = err_q;
        tmo_d     = tmo_q;

        if (cap_multi || (qual && dec_bad))
            err_d = 1'b1;

        // A capture takes priority over a timeout landing in the same cycle.
        if (qual) begin
            tmo_d    = '0;
            last_p_d = cap_p;
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    // Partial first frame is dropped; the wrap capture opens frame one.
                    if (wrap) begin
                        state_d   = RUN;
                        acc_dig_d = slot_dig;
                        acc_msk_d = slot_msk;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        digits_d  = acc_dig_q;
                        present_d = acc_msk_q;
                        fv_d      = 1'b1;
                        acc_dig_d = slot_dig;
                        acc_msk_d = slot_msk;
                    end else begin
                        acc_dig_d = acc_dig_q | slot_dig;
                        acc_msk_d = acc_msk_q | slot_msk;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d   = IDLE;
                tmo_d     = '0;
                acc_dig_d = '0;
                acc_msk_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.present_o     = present_q;
    assign bus.frame_valid_o = fv_q;
    assign bus.scan_active_o = (state_q == RUN);
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Self-checking bench for seg_scan_monitor: table of scan frames plus timeout/reset/glitch sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_monitor;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 200;
    localparam int SLOT    = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seg_scan_monitor_if bus ();

    seg_scan_monitor #(
        .STABLE_CYC  (STABLE),
        .TIMEOUT_CYC (TIMEOUT),
        .TMO_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;      // seg_data per position, position 0 in [63:56]
        logic [7:0]  lit;       // which positions are driven one-hot (bit7 = position 0)
        bit          skew;      // seg_which leads seg_data by one cycle
        logic [31:0] exp_dig;
        logic [7:0]  exp_pres;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  pres;
    } frame_t;

    vec_t   vecs[7];
    frame_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every published frame must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && bus.frame_valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got digits %h present %h, expected no frame",
                         bus.digits_o, bus.present_o);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_digits", bus.digits_o, f.dig);
                check("frame_present", {24'd0, bus.present_o}, {24'd0, f.pres});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.seg_which = 8'h00;
        bus.seg_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_slot(input logic [7:0] w, input logic [7:0] d, input bit skew, input int glitch);
        if (skew) begin
            bus.seg_which = w;
            @(negedge clk);
            bus.seg_data = d;
            repeat (SLOT - 1) @(negedge clk);
        end else begin
            bus.seg_which = w;
            bus.seg_data  = d;
            repeat (SLOT) @(negedge clk);
        end
        if (glitch > 0) begin
            // short flash of an "8" at position 0; too brief to be captured
            bus.seg_which = 8'h80;
            bus.seg_data  = 8'hFE;
            repeat (glitch) @(negedge clk);
        end
    endtask

    task automatic drive_pos(input vec_t v, input int s, input int glitch);
        logic [7:0] w;
        logic [7:0] d;
        w = v.lit[7-s] ? (8'h80 >> s) : 8'h00;
        d = v.lit[7-s] ? v.data[63-8*s -: 8] : 8'h00;
        drive_slot(w, d, v.skew, glitch);
    endtask

    // Frame 0 is consumed by SYNC; frame f is published when frame f+1 starts.
    task automatic run_frames(input vec_t v, input int nfr, input int extra, input int glitch);
        for (int f = 0; f < nfr; f++) begin
            if ((f >= 1 && f <= nfr - 2) || (f == nfr - 1 && extra > 0))
                exp_q.push_back('{v.exp_dig, v.exp_pres});
            for (int s = 0; s < 8; s++)
                drive_pos(v, s, (s == 4) ? glitch : 0);
        end
        for (int s = 0; s < extra; s++)
            drive_pos(v, s, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // patterns: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 dash=02 (bit0 = dp)
        vecs[0] = '{64'hDAF202B6F602B6B6, 8'hFF, 1'b0, 32'h23A59A55, 8'hFF, 1'b0};
        vecs[1] = '{64'hDAF202B6F602B6B6, 8'h3F, 1'b1, 32'h00A59A55, 8'h3F, 1'b0};
        vecs[2] = '{64'hDAF202A0F602B6B6, 8'hFF, 1'b0, 32'h23AF9A55, 8'hFF, 1'b1};
        vecs[3] = '{64'hFC61DAF266B6BFE0, 8'hFF, 1'b1, 32'h01234567, 8'hFF, 1'b0};
        vecs[4] = '{64'hFEF60202FC60FEF6, 8'hFF, 1'b0, 32'h89AA0189, 8'hFF, 1'b0};
        vecs[5] = '{64'hE0BEB666F2DA6000, 8'hFF, 1'b0, 32'h7654321F, 8'hFF, 1'b1};
        vecs[6] = '{64'h0000660000BE0000, 8'h24, 1'b0, 32'h00400600, 8'h24, 1'b0};

        bus.seg_which = 8'h00;
        bus.seg_data  = 8'h00;
        do_reset();
        check("reset_digits", bus.digits_o, 32'h0);
        check("reset_present", {24'd0, bus.present_o}, 32'h0);
        check("reset_fv", {31'd0, bus.frame_valid_o}, 32'h0);
        check("reset_active", {31'd0, bus.scan_active_o}, 32'h0);
        check("reset_err", {31'd0, bus.err_o}, 32'h0);

        // table-driven frames
        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_frames(vecs[i], 3, 0, 0);
            check($sformatf("vec%0d_err", i), {31'd0, bus.err_o}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_active", i), {31'd0, bus.scan_active_o}, 32'h1);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 32'h0);
            exp_q.delete();
        end

        // 3-cycle glitch after every slot 4 must never be captured
        do_reset();
        run_frames(vecs[0], 3, 0, STABLE - 1);
        check("glitch_pending", exp_q.size(), 32'h0);
        check("glitch_err", {31'd0, bus.err_o}, 32'h0);
        exp_q.delete();

        // err_o is sticky across a timeout and later clean frames
        do_reset();
        run_frames(vecs[2], 3, 0, 0);
        repeat (TIMEOUT + 20) @(negedge clk);
        check("sticky_idle", {31'd0, bus.scan_active_o}, 32'h0);
        run_frames(vecs[0], 3, 0, 0);
        check("sticky_err", {31'd0, bus.err_o}, 32'h1);
        check("sticky_pending", exp_q.size(), 32'h0);
        exp_q.delete();

        // two digit selects at once: error, no capture, no scan
        do_reset();
        bus.seg_which = 8'h81;
        bus.seg_data  = 8'hFE;
        repeat (10) @(negedge clk);
        check("multi_err", {31'd0, bus.err_o}, 32'h1);
        check("multi_active", {31'd0, bus.scan_active_o}, 32'h0);

        // timeout: the last capture is registered on the 5th rising edge of the last slot,
        // so scan_active_o must fall exactly TIMEOUT edges after that.
        do_reset();
        run_frames(vecs[0], 3, 0, 0);
        repeat (TIMEOUT + 4 - SLOT) @(negedge clk);
        check("tmo_before", {31'd0, bus.scan_active_o}, 32'h1);
        @(negedge clk);
        check("tmo_after", {31'd0, bus.scan_active_o}, 32'h0);
        check("tmo_hold_digits", bus.digits_o, 32'h23A59A55);
        check("tmo_hold_present", {24'd0, bus.present_o}, 32'hFF);
        check("tmo_pending", exp_q.size(), 32'h0);
        exp_q.delete();

        // reset in the middle of a frame clears everything at once
        do_reset();
        run_frames(vecs[0], 3, 4, 0);
        check("pre_rst_digits", bus.digits_o, 32'h23A59A55);
        rst = 1'b0;
        #1;
        check("mid_rst_digits", bus.digits_o, 32'h0);
        check("mid_rst_present", {24'd0, bus.present_o}, 32'h0);
        check("mid_rst_active", {31'd0, bus.scan_active_o}, 32'h0);
        check("mid_rst_fv", {31'd0, bus.frame_valid_o}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frames(vecs[0], 3, 0, 0);
        check("post_rst_pending", exp_q.size(), 32'h0);
        check("post_rst_active", {31'd0, bus.scan_active_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
